// File: rtl/picomem_uart_fifo_if.sv
// PicoMem bus bundle between a CPU-side master and a peripheral slave.
// One request per valid; the slave answers with a one-cycle ready pulse.
interface picomem_uart_fifo_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
  modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picomem_uart_fifo.sv
// PicoMem UART slave: TX/RX byte FIFOs, programmable baud divider, single clock domain.
// Optional IRQ_EN register and interrupt output are enabled by defining UART_FIFO_IRQ_EN.

module picomem_uart_fifo_buf #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [7:0]            wdata,
  input  logic                  pop,
  output logic [7:0]            rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] PTR_WRAP = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic                do_push, do_pop;

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = ((wptr_q ^ rptr_q) == PTR_WRAP);
  // Empty-FIFO pass-through hands the incoming byte straight to the reader.
  assign rdata = empty ? wdata : mem_q[rptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    do_push = push & (~full | pop);
    do_pop  = pop & (~empty | push);
    wptr_d  = do_push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = do_pop  ? rptr_q + PTR_ONE : rptr_q;
  end

  // NOTE: storage is not reset; the pointers are, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

module picomem_uart_fifo #(
  parameter int unsigned CLK_HZ        = 27000000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned TX_DEPTH_LOG2 = 4,
  parameter int unsigned RX_DEPTH_LOG2 = 4
) (
  input  logic                      clk,
  input  logic                      ext_reset,
  picomem_uart_fifo_if.slave        mem_s,
  input  logic                      ser_rx,
  output logic                      ser_tx,
  output logic                      irq
);
  localparam logic [15:0] DIV_RESET = 16'(CLK_HZ / BAUD);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] div_q, div_d, eff_div;
  logic        ovr_q, ovr_d, ferr_q, ferr_d;

  uart_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_per_q, tx_per_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_out_q, tx_out_d, tx_bit_end;

  uart_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_per_q, rx_per_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_sync1_q, rx_sync2_q, rx_prev_q;

  logic                   tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]             tx_rdata;
  logic [TX_DEPTH_LOG2:0] tx_count;
  logic                   rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]             rx_rdata;
  logic [RX_DEPTH_LOG2:0] rx_count;

  logic [1:0]  sel;
  logic        is_wr, tx_wr_data, accept;
  logic        clr_ovr, clr_ferr, set_ovr, set_ferr;
  logic [31:0] status;
  logic        unused_bus;

`ifdef UART_FIFO_IRQ_EN
  logic [2:0] irq_en_q, irq_en_d;
  logic       irq_q, irq_d;
`endif

  assign unused_bus = ^{mem_s.addr[31:4], mem_s.addr[1:0], mem_s.wdata[31:16]};
  assign eff_div    = (div_q < 16'd4) ? 16'd4 : div_q;
  assign status     = {8'h00, 8'(rx_count), 8'(tx_count), 3'b000,
                       ferr_q, ovr_q, rx_empty, tx_empty, tx_full};
  assign ser_tx      = tx_out_q;
  assign mem_s.ready = ready_q;
  assign mem_s.rdata = rdata_q;

  picomem_uart_fifo_buf #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .rst_n(ext_reset), .push(tx_push), .wdata(mem_s.wdata[7:0]),
    .pop(tx_pop), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  picomem_uart_fifo_buf #(.DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .rst_n(ext_reset), .push(rx_push), .wdata(rx_shift_q),
    .pop(rx_pop), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Bus decode; a DATA write into a full TX FIFO waits unless a slot frees this cycle.
  always_comb begin
    // NOTE: every variable gets a default first; a missed branch would otherwise infer a latch.
    sel        = mem_s.addr[3:2];
    is_wr      = |mem_s.wstrb;
    tx_wr_data = mem_s.valid && (sel == 2'd0) && mem_s.wstrb[0];
    accept     = mem_s.valid && !ready_q && !(tx_wr_data && tx_full && !tx_pop);
    tx_push    = accept && tx_wr_data;
    rx_pop     = accept && (sel == 2'd0) && !is_wr && !rx_empty;
    ready_d    = accept;
    rdata_d    = '0;
    div_d      = div_q;
    clr_ovr    = 1'b0;
    clr_ferr   = 1'b0;
`ifdef UART_FIFO_IRQ_EN
    irq_en_d   = irq_en_q;
`endif
    if (accept) begin
      case (sel)
        2'd0: if (!is_wr) rdata_d = rx_empty ? 32'hFFFF_FFFF : {23'b0, 1'b1, rx_rdata};
        2'd1: begin
          if (is_wr) begin
            if (mem_s.wstrb[0]) div_d[7:0]  = mem_s.wdata[7:0];
            if (mem_s.wstrb[1]) div_d[15:8] = mem_s.wdata[15:8];
          end else begin
            rdata_d = {16'b0, div_q};
          end
        end
        2'd2: begin
          if (is_wr) begin
            clr_ovr  = mem_s.wstrb[0] & mem_s.wdata[3];
            clr_ferr = mem_s.wstrb[0] & mem_s.wdata[4];
          end else begin
            rdata_d = status;
          end
        end
        default: begin
`ifdef UART_FIFO_IRQ_EN
          if (is_wr) begin
            if (mem_s.wstrb[0]) irq_en_d = mem_s.wdata[2:0];
          end else begin
            rdata_d = {29'b0, irq_en_q};
          end
`else
          if (!is_wr) rdata_d = 32'hDEAD_BEEF;
`endif
        end
      endcase
    end
    // A new error event wins over a simultaneous clear.
    ovr_d  = (ovr_q & ~clr_ovr) | set_ovr;
    ferr_d = (ferr_q & ~clr_ferr) | set_ferr;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_per_d   = tx_per_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    tx_pop     = 1'b0;
    tx_bit_end = (tx_cnt_q == tx_per_q - 16'd1);
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_out_d = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_per_d   = eff_div;
          tx_out_d   = 1'b0;
          tx_state_d = S_START;
        end
      end
      S_START: if (tx_bit_end) begin
        tx_cnt_d   = '0;
        tx_per_d   = eff_div;
        tx_bit_d   = '0;
        tx_out_d   = tx_shift_q[0];
        tx_state_d = S_DATA;
      end
      S_DATA: if (tx_bit_end) begin
        tx_cnt_d = '0;
        tx_per_d = eff_div;
        if (tx_bit_q == 3'd7) begin
          tx_out_d   = 1'b1;
          tx_state_d = S_STOP;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_out_d   = tx_shift_q[1];
        end
      end
      default: if (tx_bit_end) begin
        // Chain straight into the next start bit when more data is queued.
        tx_cnt_d = '0;
        tx_per_d = eff_div;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_rdata;
          tx_out_d   = 1'b0;
          tx_state_d = S_START;
        end else begin
          tx_out_d   = 1'b1;
          tx_state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_per_d   = rx_per_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    set_ovr    = 1'b0;
    set_ferr   = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync2_q) begin
          rx_per_d   = eff_div;
          rx_state_d = S_START;
        end
      end
      S_START: if (rx_cnt_q == (rx_per_q >> 1) - 16'd1) begin
        // Mid start bit: a high line means the falling edge was a glitch.
        rx_cnt_d   = '0;
        rx_per_d   = eff_div;
        rx_bit_d   = '0;
        rx_state_d = rx_sync2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == rx_per_q - 16'd1) begin
        rx_cnt_d   = '0;
        rx_per_d   = eff_div;
        rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
      end
      default: if (rx_cnt_q == rx_per_q - 16'd1) begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
        if (!rx_sync2_q)             set_ferr = 1'b1;
        else if (rx_full && !rx_pop) set_ovr  = 1'b1;
        else                         rx_push  = 1'b1;
      end
    endcase
  end

`ifdef UART_FIFO_IRQ_EN
  assign irq_d = (irq_en_q[0] & ~rx_empty)
               | (irq_en_q[1] & tx_empty & (tx_state_q == S_IDLE))
               | (irq_en_q[2] & (ovr_q | ferr_q));
  assign irq   = irq_q;
`else
  assign irq   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge ext_reset) begin
    if (!ext_reset) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      div_q      <= DIV_RESET;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_per_q   <= DIV_RESET;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_per_q   <= DIV_RESET;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
`ifdef UART_FIFO_IRQ_EN
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
`endif
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      div_q      <= div_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_per_q   <= tx_per_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_per_q   <= rx_per_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_sync1_q <= ser_rx;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
`ifdef UART_FIFO_IRQ_EN
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
`endif
    end
  end
endmodule
